ncpu32k_fifo_reader: RTL and testbench



---
 rtl/ncpu32k_fifo_reader_pkg.sv | 11 +
 rtl/ncpu32k_fifo_reader_if.sv | 21 ++
 rtl/ncpu32k_fifo_rd_buf.sv | 45 ++++
 rtl/ncpu32k_fifo_reader.sv | 63 ++++++
 tb/tb_ncpu32k_fifo_reader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ncpu32k_fifo_reader_pkg.sv
// Shared defaults and sizing helpers for the FIFO read-side consumer.
package ncpu32k_fifo_reader_pkg;

    localparam int BUF_DEPTH_DEF = 2;

    // Occupancy needs one extra bit so a completely full buffer is representable.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ncpu32k_fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the reader (master) side.
interface ncpu32k_fifo_reader_if #(
    parameter int DW = 32
);
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] odat;
    logic          ovalid;
    logic          iready;

    modport master (
        input  fifo_dout, fifo_empty, iready,
        output fifo_pop, odat, ovalid
    );

    modport slave (
        output fifo_dout, fifo_empty, iready,
        input  fifo_pop, odat, ovalid
    );
endinterface

// File: rtl/ncpu32k_fifo_rd_buf.sv
// BUF_DEPTH x DW ring buffer; fullness is tracked by cnt, pointers wrap with no extra bit.
module ncpu32k_fifo_rd_buf
    import ncpu32k_fifo_reader_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic [DW-1:0]                 wdat,
    input  logic                          rd_en,
    output logic [DW-1:0]                 rdat,
    output logic [occ_w(BUF_DEPTH)-1:0]   cnt
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int OW = occ_w(BUF_DEPTH);

    logic [DW-1:0] mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + OW'(wr_en) - OW'(rd_en);
        end
    end

    // Storage carries no reset; entries are only meaningful while counted by cnt.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wdat;
    end

    assign rdat = mem[rd_ptr];

endmodule

// File: rtl/ncpu32k_fifo_reader.sv
// Pop control for a registered-read FIFO: tracks the in-flight word and streams buffered data out.
module ncpu32k_fifo_reader
    import ncpu32k_fifo_reader_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ncpu32k_fifo_reader_if.master         bus,
    input  logic                          flush,
    output logic [occ_w(BUF_DEPTH)-1:0]   occupancy
);
    localparam int OW = occ_w(BUF_DEPTH);
    localparam logic [OW:0] DEPTH_X = (OW + 1)'(BUF_DEPTH);

    logic          rd_pend;
    logic          clr;
    logic          deq;
    logic          capture;
    logic [OW-1:0] cnt;
    logic [OW:0]   committed;
    logic [DW-1:0] rdat;

    assign clr       = ~rst_n | flush;
    assign deq       = bus.ovalid & bus.iready;
    assign capture   = rd_pend & ~clr;
    assign committed = {1'b0, cnt} + {{OW{1'b0}}, rd_pend};

    // A dequeue this cycle frees a slot, so popping at full keeps one word per cycle flowing.
    assign bus.fifo_pop = rst_n & ~flush & ~bus.fifo_empty & ((committed < DEPTH_X) | deq);

    always_ff @(posedge clk) begin
        if (clr)
            rd_pend <= 1'b0;
        else
            rd_pend <= bus.fifo_pop;
    end

    ncpu32k_fifo_rd_buf #(
        .DW        (DW),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .clr   (clr),
        .wr_en (capture),
        .wdat  (bus.fifo_dout),
        .rd_en (deq),
        .rdat  (rdat),
        .cnt   (cnt)
    );

    assign bus.ovalid = rst_n & (cnt != '0);
    assign bus.odat   = rdat;
    assign occupancy  = rst_n ? cnt : '0;

    always_ff @(posedge clk) begin
        if (rst_n)
            assert (committed <= DEPTH_X)
            else $error("buffer overcommitted: cnt=%0d rd_pend=%0b", cnt, rd_pend);
    end

endmodule

// File: tb/tb_ncpu32k_fifo_reader.sv
// Directed bench: FIFO model with one-cycle read latency feeding the reader, DW=8, BUF_DEPTH=2.
module tb_ncpu32k_fifo_reader;

    localparam int DW = 8;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [1:0] occupancy;

    ncpu32k_fifo_reader_if #(.DW(DW)) bus ();

    ncpu32k_fifo_reader #(.DW(DW), .BUF_DEPTH(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    int cyc = 0;
    int npops, first_pop, last_pop, first_val, last_val;
    int stab_viol, max_inf, pop_empty;
    logic pop_now, pend_m, hold_prev;
    logic [DW-1:0] hold_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        got.delete();
        npops = 0; first_pop = -1; last_pop = -1; first_val = -1; last_val = -1;
        stab_viol = 0; max_inf = 0;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) q.push_back(DW'(v));
        bus.fifo_empty = (q.size() == 0);
    endtask

    // One clock: observe the settled cycle, then advance the FIFO model past the edge.
    task automatic tick();
        #1;
        if (hold_prev && !(bus.ovalid && bus.odat == hold_dat)) stab_viol++;
        hold_prev = bus.ovalid && !bus.iready && !flush && rst_n;
        hold_dat  = bus.odat;
        if (int'(occupancy) + int'(pend_m) > max_inf) max_inf = int'(occupancy) + int'(pend_m);
        pop_now = bus.fifo_pop;
        if (bus.ovalid && bus.iready) begin
            got.push_back(bus.odat);
            if (first_val < 0) first_val = cyc;
            last_val = cyc;
        end
        if (pop_now) begin
            npops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        pend_m = pop_now;
        if (pop_now) begin
            if (q.size() == 0) pop_empty++;
            else bus.fifo_dout = q.pop_front();
        end
        bus.fifo_empty = (q.size() == 0);
    endtask

    task automatic run_until(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) tick();
    endtask

    task automatic chk_seq(input string tag, input int base, input int n);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk(tag, got[i], base + i);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        bus.iready = 1'b0; bus.fifo_dout = '0; bus.fifo_empty = 1'b1;
        pend_m = 1'b0; hold_prev = 1'b0; hold_dat = '0; pop_now = 1'b0; pop_empty = 0;
        clear_stats();

        // Reset with a non-empty FIFO: pop must stay low.
        push_range(8'h77, 8'h77);
        bus.iready = 1'b1;
        tick(); tick();
        #1;
        chk("rst_ovalid", bus.ovalid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_pop", bus.fifo_pop, 0);
        q.delete(); bus.fifo_empty = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_ovalid", bus.ovalid, 0);
        chk("idle_pop", bus.fifo_pop, 0);

        // Single word.
        clear_stats();
        push_range(8'hA5, 8'hA5);
        #1;
        chk("single_pop_c0", bus.fifo_pop, 1);
        tick(); #1;
        chk("single_ovalid_c1", bus.ovalid, 0);
        chk("single_pop_c1", bus.fifo_pop, 0);
        tick(); #1;
        chk("single_ovalid_c2", bus.ovalid, 1);
        chk("single_odat_c2", bus.odat, 8'hA5);
        tick(); #1;
        chk("single_ovalid_c3", bus.ovalid, 0);
        chk("single_pop_c3", bus.fifo_pop, 0);
        chk("single_npops", npops, 1);

        // Streaming 0x01..0x10.
        tick(); clear_stats();
        push_range(1, 16);
        run_until(16, 40);
        tick(); tick();
        chk_seq("stream", 1, 16);
        chk("stream_val_span", last_val - first_val, 15);
        chk("stream_npops", npops, 16);
        chk("stream_pop_span", last_pop - first_pop, 15);

        // Backpressure.
        clear_stats();
        bus.iready = 1'b0;
        push_range(1, 8);
        for (int k = 0; k < 10; k++) tick();
        #1;
        chk("bp_npops", npops, 2);
        chk("bp_occ", occupancy, 2);
        chk("bp_ovalid", bus.ovalid, 1);
        chk("bp_odat", bus.odat, 1);
        chk("bp_pop", bus.fifo_pop, 0);
        bus.iready = 1'b1;
        run_until(8, 30);
        chk_seq("bp", 1, 8);
        chk("bp_val_span", last_val - first_val, 7);
        chk("bp_stab", stab_viol, 0);

        // Toggling iready.
        tick(); tick(); clear_stats();
        push_range(1, 12);
        for (int k = 0; k < 80 && got.size() < 12; k++) begin
            bus.iready = ~bus.iready;
            tick();
        end
        chk_seq("tog", 1, 12);
        chk("tog_stab", stab_viol, 0);
        chk("tog_inflight", (max_inf <= BD), 1);

        // Flush with a full buffer and backpressure.
        bus.iready = 1'b0;
        tick(); tick(); clear_stats();
        push_range(8'h40, 8'h47);
        for (int k = 0; k < 6; k++) tick();
        #1;
        chk("fl_occ_before", occupancy, 2);
        flush = 1'b1;
        #1;
        chk("fl_pop_a", bus.fifo_pop, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_ovalid_after_a", bus.ovalid, 0);
        chk("fl_occ_after_a", occupancy, 0);
        bus.iready = 1'b1;
        run_until(1, 10);
        // Steady streaming: one word buffered, one in flight, deq in the flush cycle.
        #1;
        chk("fl_occ_b", occupancy, 1);
        chk("fl_pend_b", pend_m, 1);
        flush = 1'b1;
        #1;
        chk("fl_pop_b", bus.fifo_pop, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_ovalid_after_b", bus.ovalid, 0);
        chk("fl_occ_after_b", occupancy, 0);
        run_until(5, 20);
        chk("fl_count", got.size(), 5);
        chk("fl_w0", got.size() > 0 ? got[0] : 8'hxx, 8'h42);
        chk("fl_w1", got.size() > 1 ? got[1] : 8'hxx, 8'h43);
        chk("fl_w2", got.size() > 2 ? got[2] : 8'hxx, 8'h45);
        chk("fl_w3", got.size() > 3 ? got[3] : 8'hxx, 8'h46);
        chk("fl_w4", got.size() > 4 ? got[4] : 8'hxx, 8'h47);

        // Reset mid-stream.
        tick(); tick(); clear_stats();
        push_range(8'h50, 8'h5F);
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("mrst_ovalid", bus.ovalid, 0);
            chk("mrst_pop", bus.fifo_pop, 0);
            chk("mrst_occ", occupancy, 0);
            tick();
        end
        rst_n = 1'b1;
        clear_stats();
        #1;
        chk("mrst_pop_r0", bus.fifo_pop, 1);
        chk("mrst_ovalid_r0", bus.ovalid, 0);
        tick(); #1;
        chk("mrst_ovalid_r1", bus.ovalid, 0);
        tick(); #1;
        chk("mrst_ovalid_r2", bus.ovalid, 1);
        chk("mrst_odat_r2", bus.odat, 8'h54);
        run_until(12, 30);
        chk_seq("mrst", 8'h54, 12);

        chk("pop_while_empty", pop_empty, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
